vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of vga_adapter (x, y, colour, plot) between NREQ pixel producers, e.g. board scan, next-piece preview, score digits and the game-over banner.
- Uses round-robin arbitration with at most one pixel per cycle.
- Contains a full-screen clear engine that has priority over all requesters.
- Sits between the drawing engines and vga_adapter in the top level.

Parameters:
- NREQ, 3, number of requesters (2..8).
- WIDTH, 160, screen width in pixels.
- HEIGHT, 120, screen height in pixels.
- CLEAR_ON_RESET, 1, when 1 a clear to colour 3'b000 starts automatically on reset.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester pixel request.
- req_x  in  NREQ*8  packed x coordinates; requester i uses bits [8i+7:8i].
- req_y  in  NREQ*7  packed y coordinates; requester i uses bits [7i+6:7i].
- req_colour  in  NREQ*3  packed colours; requester i uses bits [3i+2:3i].
- grant  out  NREQ  one-hot combinational grant.
- clear_start  in  1  one-cycle pulse that starts a full-screen clear.
- clear_colour  in  3  fill colour, sampled on the clear_start cycle.
- clear_busy  out  1  high while the clear engine owns the port.
- vga_x  out  8  pixel x to vga_adapter.
- vga_y  out  7  pixel y to vga_adapter.
- vga_colour  out  3  pixel colour to vga_adapter.
- vga_plot  out  1  write strobe to vga_adapter.

Behaviour:
- States: ARB and CLEAR. A round-robin pointer ptr in [0, NREQ-1] records the next requester to favour.

Reset (rst high at a clock edge):
- vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, ptr=0, clear counters cx=cy=0, latched colour=0.
- If CLEAR_ON_RESET=1: state=CLEAR and clear_busy=1. Otherwise state=ARB and clear_busy=0.
- rst aborts any clear in progress. While rst is high, grant=0.

ARB state:
- grant is combinational. grant[i]=1 for the first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
- Grant is zero if clear_start=1, if state is not ARB, or if no request is present.
- Requester protocol: hold req and data stable until it sees grant high at a clock edge. The pixel is consumed at that edge. The requester may present its next pixel in the following cycle, and may keep req high back-to-back.
- On a grant to requester i at edge t: ptr <= (i+1) mod NREQ. At t+1, vga_x/y/colour = that requester's data and vga_plot=1.
- Latency is exactly 1 cycle. vga_plot is high for exactly one cycle per granted pixel.
- Out-of-range pixel (x>=WIDTH or y>=HEIGHT): it is granted and consumed, ptr advances, and vga_plot=0 in the following cycle.
- Cycles with no grant: vga_plot=0 and vga_x/y/colour hold their previous values.
- clear_start=1 in ARB: it wins over every request in that cycle. Latch clear_colour, set cx=cy=0, go to CLEAR, clear_busy<=1. ptr is unchanged.

CLEAR state:
- Each cycle: emit (cx, cy, latched colour) on the vga_* registers with vga_plot=1.
- Counter advance: cx++. When cx==WIDTH-1, set cx=0 and cy++.
- The cycle that emits (WIDTH-1, HEIGHT-1) also sets state<=ARB and clear_busy<=0.
- Emission is raster order, x fastest. Total is WIDTH*HEIGHT plot cycles (19200 at defaults).
- The first clear pixel appears on the edge after entering CLEAR.
- grant=0 throughout CLEAR. clear_start is ignored in CLEAR; there is no restart.
- Requests held during CLEAR are served in ARB starting from the unchanged ptr.
- The first ARB cycle after CLEAR may grant. Its pixel appears the cycle after the last clear pixel, with no bubble required.

Width rules:
- cx is 8 bits and cy is 7 bits.
- The comparisons against WIDTH-1 and HEIGHT-1 are exact, with no overflow.

Test Plan:
1. CLEAR_ON_RESET=1: pulse rst, no requests -> clear_busy=1. vga_plot high for exactly 19200 consecutive cycles, covering (0,0),(1,0)...(159,0),(0,1)...(159,119), colour 0. Then clear_busy=0 and vga_plot=0.
2. After the clear, hold req=3'b111 for 6 cycles with distinct data -> grant sequence 001,010,100,001,010,100. Each pixel appears 1 cycle later with vga_plot=1.
3. req=3'b010 only, held continuously with x=10, y=20, colour=5 -> grant[1] every cycle. vga_x=10, vga_y=20, vga_colour=5, vga_plot=1 on every following cycle.
4. clear_start with clear_colour=3'b111 in the same cycle as req=3'b001 -> no grant that cycle. 19200 white pixels follow. grant[0] is asserted on the first ARB cycle, and its pixel follows the last clear pixel directly.
5. Requester 2 presents x=160, y=5 -> granted, ptr advances, vga_plot=0 next cycle.
6. Assert rst midway through a clear (cx=37, cy=50) with CLEAR_ON_RESET=0 -> next cycle state=ARB, clear_busy=0, vga_plot=0, ptr=0.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel-write port between NREQ
// producers, with a full-screen clear engine that takes priority over them.
module vga_plot_arbiter #(
  parameter int NREQ           = 3,
  parameter int WIDTH          = 160,
  parameter int HEIGHT         = 120,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*8-1:0]        req_x,
  input  logic [NREQ*7-1:0]        req_y,
  input  logic [NREQ*3-1:0]        req_colour,
  output logic [NREQ-1:0]          grant,
  input  logic                     clear_start,
  input  logic [2:0]               clear_colour,
  output logic                     clear_busy,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output logic                     dbg_state,
  output logic [$clog2(NREQ)-1:0]  dbg_ptr
);

  localparam int PW = $clog2(NREQ);

  // Handshake: a requester holds req and its data stable until grant is seen
  // high at a rising edge; that edge consumes the pixel, which is driven on
  // vga_* with vga_plot one cycle later.
  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [7:0]    cx_q;
  logic [6:0]    cy_q;
  logic [2:0]    colour_q;

  logic          found;
  logic [PW-1:0] gidx;
  logic [PW-1:0] nxt_ptr;
  logic [7:0]    sel_x;
  logic [6:0]    sel_y;
  logic [2:0]    sel_colour;
  logic          sel_in_range;
  logic          grant_any;
  logic          last_px;

  // Two-pass search: first from ptr upward, then wrap to the low indices.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr_q))) begin
        found = 1'b1;
        gidx  = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        gidx  = PW'(i);
      end
    end

    grant = '0;
    if (found && (state_q == ARB) && !clear_start && !rst) grant[gidx] = 1'b1;
    grant_any = |grant;

    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == PW'(i)) begin
        sel_x      = req_x[8*i +: 8];
        sel_y      = req_y[7*i +: 7];
        sel_colour = req_colour[3*i +: 3];
      end
    end
    sel_in_range = (int'(sel_x) < WIDTH) && (int'(sel_y) < HEIGHT);
    nxt_ptr      = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  end

  assign last_px    = (cx_q == 8'(WIDTH - 1)) && (cy_q == 7'(HEIGHT - 1));
  assign clear_busy = (state_q == CLEAR);
  assign dbg_state  = (state_q == CLEAR);
  assign dbg_ptr    = ptr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (clear_start) state_d = CLEAR;
      CLEAR:   if (last_px) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : ARB;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      ptr_q      <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      colour_q   <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (clear_start) begin
            colour_q <= clear_colour;
            cx_q     <= '0;
            cy_q     <= '0;
            vga_plot <= 1'b0;
          end else if (grant_any) begin
            // Off-screen pixels are still consumed, just never strobed.
            ptr_q      <= nxt_ptr;
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
            vga_plot   <= sel_in_range;
          end else begin
            vga_plot <= 1'b0;
          end
        end
        CLEAR: begin
          vga_x      <= cx_q;
          vga_y      <= cy_q;
          vga_colour <= colour_q;
          vga_plot   <= 1'b1;
          if (cx_q == 8'(WIDTH - 1)) begin
            cx_q <= '0;
            if (!last_px) cy_q <= cy_q + 7'd1;
          end else begin
            cx_q <= cx_q + 8'd1;
          end
        end
        default: vga_plot <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: clear engine, round-robin rotation, held and
// off-screen requests, randomized traffic against a reference model, resets.
module tb_vga_plot_arbiter;

  localparam int W = 160;
  localparam int H = 120;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] req_x = '0;
  logic [20:0] req_y = '0;
  logic [8:0]  req_colour = '0;
  logic [2:0]  grant;
  logic        clear_start = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        clear_busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        dbg_state;
  logic [1:0]  dbg_ptr;

  logic        rst0 = 1'b1;
  logic [2:0]  req0 = '0;
  logic [23:0] req0_x = '0;
  logic [20:0] req0_y = '0;
  logic [8:0]  req0_colour = '0;
  logic [2:0]  grant0;
  logic        clear_start0 = 1'b0;
  logic [2:0]  clear_colour0 = '0;
  logic        clear_busy0;
  logic [7:0]  vga_x0;
  logic [6:0]  vga_y0;
  logic [2:0]  vga_colour0;
  logic        vga_plot0;
  logic        dbg_state0;
  logic [1:0]  dbg_ptr0;

  vga_plot_arbiter #(.NREQ(3), .WIDTH(W), .HEIGHT(H), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .clear_start(clear_start),
    .clear_colour(clear_colour), .clear_busy(clear_busy), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  vga_plot_arbiter #(.NREQ(3), .WIDTH(W), .HEIGHT(H), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .req_x(req0_x), .req_y(req0_y),
    .req_colour(req0_colour), .grant(grant0), .clear_start(clear_start0),
    .clear_colour(clear_colour0), .clear_busy(clear_busy0), .vga_x(vga_x0),
    .vga_y(vga_y0), .vga_colour(vga_colour0), .vga_plot(vga_plot0),
    .dbg_state(dbg_state0), .dbg_ptr(dbg_ptr0)
  );

  int checks = 0;
  int errors = 0;

  // requester model state: {plot, x, y, colour}
  logic [18:0] exp_q[$];
  logic        rv[3];
  logic [7:0]  rx[3];
  logic [6:0]  ry[3];
  logic [2:0]  rc[3];
  int          m_ptr = 0;

  // driver tasks
  task automatic pack();
    for (int i = 0; i < 3; i++) begin
      req[i]              = rv[i];
      req_x[8*i +: 8]     = rx[i];
      req_y[7*i +: 7]     = ry[i];
      req_colour[3*i +: 3] = rc[i];
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] x,
                         input logic [6:0] y, input logic [2:0] c);
    rv[i] = v; rx[i] = x; ry[i] = y; rc[i] = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: first requester at or after p, wrapping; -1 if none
  function automatic int rr_pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++)
      if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 8'(i + 1), 7'(i + 2), 3'(i + 3));
    pack();
    rst = 1'b1;
    step();
    checks++;
    if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b want 000", grant); end
    checks++;
    if ({vga_plot, vga_x, vga_y, vga_colour, dbg_ptr} !== '0) begin
      errors++;
      $display("FAIL reset_regs got plot=%b x=%0d y=%0d c=%0d ptr=%0d want all 0",
               vga_plot, vga_x, vga_y, vga_colour, dbg_ptr);
    end
    checks++;
    if (clear_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", clear_busy); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) rv[i] = 1'b0;
    pack();
  endtask

  task automatic test_clear_on_reset();
    bit bad = 0;
    int n = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        step();
        if (!bad) begin
          checks++;
          if (vga_plot !== 1'b1 || vga_x !== 8'(x) || vga_y !== 7'(y) || vga_colour !== 3'd0 ||
              clear_busy !== (n != W * H - 1)) begin
            bad = 1; errors++;
            $display("FAIL clear_px%0d got plot=%b x=%0d y=%0d c=%0d busy=%b want 1 %0d %0d 0",
                     n, vga_plot, vga_x, vga_y, vga_colour, clear_busy, x, y);
          end
        end
        n++;
      end
    end
    step();
    checks++;
    if (vga_plot !== 1'b0 || clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_end got plot=%b busy=%b want 0 0", vga_plot, clear_busy);
    end
  endtask

  task automatic test_rotation();
    int g;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 8'(10 + i), 7'(20 + i), 3'(i + 1));
    for (int k = 0; k < 6; k++) begin
      pack();
      #1;
      g = k % 3;
      checks++;
      if (grant !== 3'(1 << g)) begin errors++; $display("FAIL rot_grant%0d got %b want %b", k, grant, 3'(1 << g)); end
      step();
      checks++;
      if (vga_plot !== 1'b1 || vga_x !== rx[g] || vga_y !== ry[g] || vga_colour !== rc[g]) begin
        errors++;
        $display("FAIL rot_px%0d got plot=%b x=%0d y=%0d c=%0d want 1 %0d %0d %0d",
                 k, vga_plot, vga_x, vga_y, vga_colour, rx[g], ry[g], rc[g]);
      end
      set_req(g, 1'b1, 8'(30 + 10 * k + g), 7'(40 + k), 3'(7 - g));
    end
    for (int i = 0; i < 3; i++) rv[i] = 1'b0;
    pack();
  endtask

  task automatic test_hold();
    set_req(1, 1'b1, 8'd10, 7'd20, 3'd5);
    pack();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (grant !== 3'b010) begin errors++; $display("FAIL hold_grant%0d got %b want 010", k, grant); end
      step();
      checks++;
      if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd10, 7'd20, 3'd5}) begin
        errors++;
        $display("FAIL hold_px%0d got plot=%b x=%0d y=%0d c=%0d want 1 10 20 5",
                 k, vga_plot, vga_x, vga_y, vga_colour);
      end
    end
    rv[1] = 1'b0;
    pack();
    step();
    checks++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b0, 8'd10, 7'd20, 3'd5}) begin
      errors++;
      $display("FAIL idle_hold got plot=%b x=%0d y=%0d c=%0d want 0 10 20 5",
               vga_plot, vga_x, vga_y, vga_colour);
    end
  endtask

  task automatic test_out_of_range();
    set_req(2, 1'b1, 8'd160, 7'd5, 3'd6);
    pack();
    #1;
    checks++;
    if (grant !== 3'b100) begin errors++; $display("FAIL oor_grant got %b want 100", grant); end
    step();
    rv[2] = 1'b0;
    pack();
    checks++;
    if (vga_plot !== 1'b0 || dbg_ptr !== 2'd0) begin
      errors++;
      $display("FAIL oor_result got plot=%b ptr=%0d want 0 0", vga_plot, dbg_ptr);
    end
  endtask

  task automatic test_random();
    int gi;
    logic [18:0] e;
    logic [2:0] rvec;
    m_ptr = 0;
    for (int i = 0; i < 3; i++)
      set_req(i, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 170)),
              7'($urandom_range(0, 125)), 3'($urandom_range(0, 7)));
    for (int n = 0; n < 300; n++) begin
      pack();
      #1;
      rvec = {rv[2], rv[1], rv[0]};
      gi = rr_pick(rvec, m_ptr);
      checks++;
      if (grant !== ((gi >= 0) ? 3'(1 << gi) : 3'b000)) begin
        errors++; $display("FAIL rand_grant%0d got %b req %b ptr %0d", n, grant, rvec, m_ptr);
      end
      if (gi >= 0) begin
        exp_q.push_back({(rx[gi] < W) && (ry[gi] < H), rx[gi], ry[gi], rc[gi]});
        m_ptr = (gi + 1) % 3;
      end else begin
        exp_q.push_back('0);
      end
      step();
      e = exp_q.pop_front();
      checks++;
      if (vga_plot !== e[18] || (e[18] && {vga_x, vga_y, vga_colour} !== e[17:0])) begin
        errors++;
        $display("FAIL rand_px%0d got plot=%b x=%0d y=%0d c=%0d want %b %0d %0d %0d",
                 n, vga_plot, vga_x, vga_y, vga_colour, e[18], e[17:10], e[9:3], e[2:0]);
      end
      checks++;
      if (dbg_ptr !== 2'(m_ptr)) begin errors++; $display("FAIL rand_ptr%0d got %0d want %0d", n, dbg_ptr, m_ptr); end
      for (int i = 0; i < 3; i++)
        if (i == gi || !rv[i])
          set_req(i, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 170)),
                  7'($urandom_range(0, 125)), 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 3; i++) rv[i] = 1'b0;
    pack();
    step();
  endtask

  task automatic test_clear_start();
    bit bad = 0;
    int n = 0;
    for (int i = 0; i < 3; i++) rv[i] = 1'b0;
    set_req(0, 1'b1, 8'd7, 7'd9, 3'd3);
    pack();
    clear_start = 1'b1;
    clear_colour = 3'b111;
    #1;
    checks++;
    if (grant !== 3'b000) begin errors++; $display("FAIL cs_grant got %b want 000", grant); end
    step();
    clear_start = 1'b0;
    clear_colour = 3'b000;
    checks++;
    if (clear_busy !== 1'b1 || vga_plot !== 1'b0) begin
      errors++; $display("FAIL cs_enter got busy=%b plot=%b want 1 0", clear_busy, vga_plot);
    end
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (!bad) begin
          checks++;
          if (grant !== 3'b000 || clear_busy !== 1'b1) begin
            bad = 1; errors++;
            $display("FAIL cs_busy%0d got grant=%b busy=%b want 000 1", n, grant, clear_busy);
          end
        end
        if (n == 5000) begin clear_start = 1'b1; clear_colour = 3'b010; end
        step();
        clear_start = 1'b0;
        if (!bad) begin
          checks++;
          if (vga_plot !== 1'b1 || vga_x !== 8'(x) || vga_y !== 7'(y) || vga_colour !== 3'b111) begin
            bad = 1; errors++;
            $display("FAIL cs_px%0d got plot=%b x=%0d y=%0d c=%0d want 1 %0d %0d 7",
                     n, vga_plot, vga_x, vga_y, vga_colour, x, y);
          end
        end
        n++;
      end
    end
    checks++;
    if (clear_busy !== 1'b0 || grant !== 3'b001) begin
      errors++; $display("FAIL cs_exit got busy=%b grant=%b want 0 001", clear_busy, grant);
    end
    step();
    checks++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd7, 7'd9, 3'd3}) begin
      errors++;
      $display("FAIL cs_first_arb got plot=%b x=%0d y=%0d c=%0d want 1 7 9 3",
               vga_plot, vga_x, vga_y, vga_colour);
    end
    rv[0] = 1'b0;
    pack();
    step();
  endtask

  task automatic test_reset_mid_clear();
    rst0 = 1'b0;
    checks++;
    if (dbg_state0 !== 1'b0 || clear_busy0 !== 1'b0 || vga_plot0 !== 1'b0) begin
      errors++;
      $display("FAIL nc_reset got state=%b busy=%b plot=%b want 0 0 0", dbg_state0, clear_busy0, vga_plot0);
    end
    req0 = 3'b010;
    req0_x[15:8] = 8'd3; req0_y[13:7] = 7'd4; req0_colour[5:3] = 3'd1;
    #1;
    checks++;
    if (grant0 !== 3'b010) begin errors++; $display("FAIL nc_grant got %b want 010", grant0); end
    step();
    req0 = 3'b000;
    checks++;
    if (dbg_ptr0 !== 2'd2) begin errors++; $display("FAIL nc_ptr got %0d want 2", dbg_ptr0); end
    clear_start0 = 1'b1;
    clear_colour0 = 3'd5;
    step();
    clear_start0 = 1'b0;
    repeat (50 * W + 37) @(posedge clk);
    #1;
    checks++;
    if ({vga_plot0, vga_x0, vga_y0, vga_colour0, clear_busy0} !== {1'b1, 8'd36, 7'd50, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL mid_clear got plot=%b x=%0d y=%0d c=%0d busy=%b want 1 36 50 5 1",
               vga_plot0, vga_x0, vga_y0, vga_colour0, clear_busy0);
    end
    rst0 = 1'b1;
    req0 = 3'b001;
    #1;
    checks++;
    if (grant0 !== 3'b000) begin errors++; $display("FAIL rst_grant got %b want 000", grant0); end
    step();
    rst0 = 1'b0;
    checks++;
    if ({dbg_state0, clear_busy0, vga_plot0, dbg_ptr0} !== 5'b0) begin
      errors++;
      $display("FAIL abort got state=%b busy=%b plot=%b ptr=%0d want 0 0 0 0",
               dbg_state0, clear_busy0, vga_plot0, dbg_ptr0);
    end
    #1;
    checks++;
    if (grant0 !== 3'b001) begin errors++; $display("FAIL post_abort_grant got %b want 001", grant0); end
    req0 = 3'b000;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, '0, '0, '0);
    test_reset();
    test_clear_on_reset();
    test_rotation();
    test_hold();
    test_out_of_range();
    test_random();
    test_clear_start();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
